// File: rtl/product_accumulator_if.sv
// Bus between the multiplier-side driver and the product accumulator:
// start/clear/product go in, the running sum and status come out.
interface product_accumulator_if #(
  parameter int unsigned ACC_W = 12
) ();

  logic             start;
  logic             clear;
  logic [7:0]       product;
  logic [ACC_W-1:0] acc_sum;
  logic [7:0]       term_cnt;
  logic             busy;
  logic             done;
  logic             overflow;

  modport master (
    output start, clear, product,
    input  acc_sum, term_cnt, busy, done, overflow
  );

  modport slave (
    input  start, clear, product,
    output acc_sum, term_cnt, busy, done, overflow
  );

endinterface

// File: rtl/product_accumulator.sv
// Samples the multiplier product LATENCY cycles after each start and
// accumulates N_TERMS of them into a wrapping sum with a sticky overflow flag.
module product_accumulator #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 12
) (
  input  logic                  clk,
  input  logic                  n_rst,
  product_accumulator_if.slave  bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned TERM_W = 8;
  localparam int unsigned SUM_W  = ACC_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   lat_cnt, lat_cnt_n;
  logic [ACC_W-1:0]   acc_sum, acc_sum_n;
  logic [TERM_W-1:0]  term_cnt, term_cnt_n;
  logic               busy, busy_n;
  logic               done, done_n;
  logic               overflow, overflow_n;
  logic [SUM_W-1:0]   sum_ext;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      acc_sum  <= '0;
      term_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      lat_cnt  <= lat_cnt_n;
      acc_sum  <= acc_sum_n;
      term_cnt <= term_cnt_n;
      busy     <= busy_n;
      done     <= done_n;
      overflow <= overflow_n;
    end
  end

  always_comb begin
    state_n    = state;
    lat_cnt_n  = lat_cnt;
    acc_sum_n  = acc_sum;
    term_cnt_n = term_cnt;
    done_n     = done;
    overflow_n = overflow;
    // Extra top bit captures the carry out of the ACC_W-bit add.
    sum_ext    = {1'b0, acc_sum} + SUM_W'(bus.product);

    if (bus.clear) begin
      state_n    = IDLE;
      lat_cnt_n  = '0;
      acc_sum_n  = '0;
      term_cnt_n = '0;
      done_n     = 1'b0;
      overflow_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state_n   = WAIT;
            lat_cnt_n = CNT_W'(LATENCY - 1);
          end
        end
        WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt_n = lat_cnt - CNT_W'(1);
          end else begin
            acc_sum_n  = sum_ext[ACC_W-1:0];
            term_cnt_n = term_cnt + TERM_W'(1);
            if (sum_ext[ACC_W]) overflow_n = 1'b1;
            if (term_cnt_n == TERM_W'(N_TERMS)) begin
              state_n = DONE;
              done_n  = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end
        end
        DONE: begin
          // A start here opens a fresh run in the same edge.
          if (bus.start) begin
            state_n    = WAIT;
            lat_cnt_n  = CNT_W'(LATENCY - 1);
            acc_sum_n  = '0;
            term_cnt_n = '0;
            done_n     = 1'b0;
            overflow_n = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    busy_n = (state_n == WAIT);
  end

  assign bus.acc_sum  = acc_sum;
  assign bus.term_cnt = term_cnt;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.overflow = overflow;

endmodule
